shift_rr_arbiter: RTL and testbench

Shares one 8-bit logical-right barrel shifter among NREQ requesters. A round-robin arbiter picks one pending request per cycle and applies its shift amount in the shared 3-stage (4/2/1) zero-fill shifter datapath. The result goes into a one-entry output register with a valid/ready handshake. The block sits between the shift clients and the downstream consumer, and it is the only instance of the shifter datapath in the subsystem.

---
 rtl/shift_rr_arbiter.sv | 110 +++++++++++
 tb/tb_shift_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rr_arbiter.sv
// Round-robin arbiter that shares one 8-bit logical-right barrel shifter among NREQ
// requesters, with a one-entry valid/ready result register.
module shift_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [3*NREQ-1:0] req_ctrl,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  logic [DW-1:0]  data_arr [NREQ];
  logic [CW-1:0]  ctrl_arr [NREQ];

  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;

  logic [IDW-1:0] grant_id_c;
  logic           slot_free_c;
  logic           accept_c;
  logic [DW-1:0]  op_c, s4_c, s2_c, s1_c;
  logic [CW-1:0]  amt_c;

  // Unpack flat request buses into per-requester lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign data_arr[i] = req_data[DW*i +: DW];
    assign ctrl_arr[i] = req_ctrl[CW*i +: CW];
  end

  // Search starts just after the last winner and wraps modulo NREQ.
  always_comb begin
    logic [IDW-1:0] idx;
    logic           found;
    grant_id_c = '0;
    idx        = '0;
    found      = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        grant_id_c = idx;
        found      = 1'b1;
      end
    end
  end

  assign slot_free_c = !rsp_valid_q || rsp_ready;
  assign accept_c    = slot_free_c && (|req_valid);

  // Shared three-stage zero-fill shifter: 4, then 2, then 1.
  always_comb begin
    op_c  = data_arr[grant_id_c];
    amt_c = ctrl_arr[grant_id_c];
    s4_c  = amt_c[2] ? {4'b0, op_c[7:4]} : op_c;
    s2_c  = amt_c[1] ? {2'b0, s4_c[7:2]} : s4_c;
    s1_c  = amt_c[0] ? {1'b0, s2_c[7:1]} : s2_c;
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && accept_c) begin
      req_ready[grant_id_c] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (accept_c) begin
      rsp_valid_d  = 1'b1;
      rsp_data_d   = s1_c;
      rsp_id_d     = grant_id_c;
      last_grant_d = grant_id_c;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Scoreboard bench for shift_rr_arbiter: directed scenarios followed by random traffic
// checked against a behavioural round-robin/shift model.
module tb_shift_rr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef struct {
    logic [7:0] data;
    int         id;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [3*NREQ-1:0] req_ctrl;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;

  int checks = 0;
  int passes = 0;

  rsp_t       exp_q[$];
  int         m_ptr;
  bit         m_full;
  logic [NREQ-1:0] last_exp_ready;

  shift_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ctrl(req_ctrl),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic set_req(input int i, input bit v, input logic [7:0] d, input logic [2:0] c);
    req_valid[i]        = v;
    req_data[8*i +: 8]  = d;
    req_ctrl[3*i +: 3]  = c;
  endtask

  task automatic model_reset();
    m_ptr  = NREQ - 1;
    m_full = 1'b0;
    exp_q.delete();
  endtask

  // One clock of the reference model: inputs already driven; checks combinational
  // grant and result-valid state at negedge, then advances to just after posedge.
  task automatic cycle();
    int g;
    bit acc;
    logic [NREQ-1:0] er;
    logic [7:0] d;
    int c;
    @(negedge clk);
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[i]) g = i;
    end
    acc = (!m_full || rsp_ready) && (g >= 0);
    er  = '0;
    if (acc) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    last_exp_ready = er;
    if (acc) begin
      d = req_data[8*g +: 8];
      c = int'(req_ctrl[3*g +: 3]);
      exp_q.push_back('{data: d >> c, id: g});
      m_ptr  = g;
      m_full = 1'b1;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever a result is presented it must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    req_ctrl  = '0;
    rsp_ready = 1'b1;
    last_exp_ready = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Single request with shift 3.
    set_req(0, 1'b1, 8'hB6, 3'd3);
    cycle();
    req_valid = '0;
    cycle();
    chk("t1_rsp_data", 32'(rsp_data), 32'h16);

    // Shift-amount sweep on requester 2.
    for (int a = 0; a < 8; a++) begin
      set_req(2, 1'b1, 8'hFF, 3'(a));
      cycle();
    end
    req_valid = '0;
    cycle();

    // Fairness with all requesters active.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h11 * (i + 1)), 3'(i));
    repeat (6) cycle();
    req_valid = '0;
    cycle();

    // Backpressure holding 8'h40 while requesters 1 and 3 wait.
    set_req(0, 1'b1, 8'h80, 3'd1);
    cycle();
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 8'hC3, 3'd2);
    set_req(3, 1'b1, 8'h5A, 3'd4);
    repeat (5) begin
      cycle();
      chk("t4_hold_data", 32'(rsp_data), 32'h40);
    end
    rsp_ready = 1'b1;
    cycle();
    req_valid[1] = 1'b0;
    cycle();
    req_valid = '0;
    cycle();

    // Pointer holds across idle cycles.
    set_req(2, 1'b1, 8'h0F, 3'd0);
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    set_req(0, 1'b1, 8'hAA, 3'd1);
    set_req(3, 1'b1, 8'h55, 3'd2);
    cycle();
    chk("t5_grant3", 32'(last_exp_ready), 32'b1000);
    req_valid[3] = 1'b0;
    cycle();
    req_valid = '0;
    cycle();

    // Reset while a result is in flight and requester 3 waits.
    set_req(0, 1'b1, 8'h99, 3'd0);
    rsp_ready = 1'b0;
    cycle();
    req_valid = '0;
    set_req(3, 1'b1, 8'h77, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 8'h3C, 3'd2);
    cycle();
    chk("t6_grant1", 32'(last_exp_ready), 32'b0010);
    req_valid[1] = 1'b0;
    cycle();
    req_valid = '0;
    cycle();

    // Random traffic: requesters hold stable until granted.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_exp_ready[i]) begin
          set_req(i, ($urandom_range(0, 99) < 60), 8'($urandom), 3'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      cycle();
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
